mux_sel_arbiter: RTL and testbench

//   Two-requester round-robin arbiter that drives the sel input of mux_2to1.

---
 rtl/mux_sel_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter that drives the sel input of a 2:1 mux.
// Optional grant lock input enabled by defining ARB_LOCK_EN.
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             done,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX - 1);

    state_t state;
    logic   last;
    logic   cur_req;
    logic   oth_req;
    logic   at_limit;
    logic   locked;
    logic   timeout;
    logic   rel;

    // Release decision for the current grantee, seen from its own side.
    always_comb begin
        cur_req  = (state == GNT1) ? req1 : req0;
        oth_req  = (state == GNT1) ? req0 : req1;
        at_limit = (hold_cnt == LIMIT);
`ifdef ARB_LOCK_EN
        locked   = lock;
`else
        locked   = 1'b0;
`endif
        timeout  = at_limit & oth_req & ~locked;
        rel      = ~cur_req | done | timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    // On a tie, last==1 hands the grant to source 0.
                    if (req0 && (!req1 || last)) begin
                        state <= GNT0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                        sel   <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b1;
                    end else if (req1) begin
                        state <= GNT1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                        sel   <= 1'b1;
                        last  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (rel) begin
                        hold_cnt <= '0;
                        if (oth_req) begin
                            // Hand over directly, no idle bubble.
                            if (state == GNT0) begin
                                state <= GNT1;
                                gnt0  <= 1'b0;
                                gnt1  <= 1'b1;
                                sel   <= 1'b1;
                                last  <= 1'b1;
                            end else begin
                                state <= GNT0;
                                gnt0  <= 1'b1;
                                gnt1  <= 1'b0;
                                sel   <= 1'b0;
                                last  <= 1'b0;
                            end
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end else if (at_limit) begin
                        hold_cnt <= locked ? LIMIT : '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Testbench for mux_sel_arbiter: fixed vector table, randomized run against a
// behavioural model, and the lock sequence when ARB_LOCK_EN is defined.
module tb_mux_sel_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 3;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_SUPPORTED = 1'b1;
`else
    localparam bit LOCK_SUPPORTED = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req0;
    logic             req1;
    logic             done;
    logic             lock;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             busy;
    logic [CNT_W-1:0] hold_cnt;
    logic [7:0]       i0;
    logic [7:0]       i1;
    logic [7:0]       y;

    int tests = 0;
    int fails = 0;

    // Behavioural model: owner -1 means nobody holds the mux path.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 1;
    int m_sel   = 0;

    typedef struct {
        bit rst;
        bit req0;
        bit req1;
        bit done;
        bit g0;
        bit g1;
        bit sel;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mux_sel_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .done     (done),
`ifdef ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel      (sel),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    // The downstream 2:1 mux steered by the arbiter's sel.
    assign y = sel ? i1 : i0;

    function automatic void addVec(bit r, bit q0, bit q1, bit d, bit g0, bit g1, bit s, int c);
        vec_t v;
        v.rst = r;  v.req0 = q0; v.req1 = q1; v.done = d;
        v.g0  = g0; v.g1   = g1; v.sel  = s;  v.cnt  = c;
        vecs.push_back(v);
    endfunction

    task automatic grantTo(input int p);
        m_owner = p;
        m_cnt   = 0;
        m_last  = p;
        m_sel   = p;
    endtask

    task automatic modelStep(input bit r, input bit q0, input bit q1, input bit d, input bit lk);
        bit req[2];
        int other;
        bit locked;
        bit timed_out;
        req[0] = q0;
        req[1] = q1;
        if (r) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 1;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            if (q0 && q1) grantTo(1 - m_last);
            else if (q0)  grantTo(0);
            else if (q1)  grantTo(1);
        end else begin
            other     = 1 - m_owner;
            locked    = LOCK_SUPPORTED && lk;
            timed_out = (m_cnt == HOLD_MAX - 1) && req[other] && !locked;
            if (!req[m_owner] || d || timed_out) begin
                if (req[other]) grantTo(other);
                else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else if (m_cnt < HOLD_MAX - 1) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_cnt = locked ? HOLD_MAX - 1 : 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit q0, input bit q1, input bit d, input bit lk);
        rst  = r;
        req0 = q0;
        req1 = q1;
        done = d;
        lock = lk;
        i0   = 8'($urandom);
        i1   = 8'($urandom);
        @(posedge clk);
        modelStep(r, q0, q1, d, lk);
        #1;
    endtask

    task automatic compare(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input bit eg0, input bit eg1, input bit esel, input int ecnt);
        compare({tag, " gnt0"}, int'(gnt0), int'(eg0));
        compare({tag, " gnt1"}, int'(gnt1), int'(eg1));
        compare({tag, " sel"}, int'(sel), int'(esel));
        compare({tag, " busy"}, int'(busy), int'(eg0 | eg1));
        compare({tag, " hold_cnt"}, int'(hold_cnt), ecnt);
        compare({tag, " mux y"}, int'(y), int'(esel ? i1 : i0));
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0; lock = 1'b0;
        i0 = 8'h00; i1 = 8'h00;

        // Reset held two cycles with both requesting, then 16 cycles of contention.
        addVec(1, 1, 1, 0, 0, 0, 0, 0);
        addVec(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            addVec(0, 1, 1, 0, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, ((i / 4) % 2) == 1, i % 4);
        end
        // Source 1 alone: grant continues and hold_cnt wraps.
        for (int i = 0; i < 10; i++) begin
            addVec(0, 0, 1, 0, 0, 1, 1, i % 4);
        end
        // Early release by done, with and without a waiting contender.
        addVec(0, 1, 0, 0, 1, 0, 0, 0);
        addVec(0, 1, 0, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 1, 0, 1, 1, 0);
        addVec(0, 1, 0, 0, 1, 0, 0, 0);
        addVec(0, 1, 0, 0, 1, 0, 0, 1);
        addVec(0, 1, 0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-grant, then the tie after reset goes to source 0 again.
        addVec(0, 0, 1, 0, 0, 1, 1, 0);
        addVec(0, 0, 1, 0, 0, 1, 1, 1);
        addVec(1, 0, 1, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 1, 0, 0, 0);
        // done is ignored in IDLE; sel holds its last value while idle.
        addVec(0, 0, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 1, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 0);
        addVec(0, 1, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req0, vecs[i].req1, vecs[i].done, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].sel, vecs[i].cnt);
        end

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 1) == 1);
            checkOutput($sformatf("rand%0d", i), m_owner == 0, m_owner == 1, m_sel[0], m_cnt);
        end

`ifdef ARB_LOCK_EN
        // Lock masks the timeout: source 0 keeps the path, hold_cnt saturates.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lock reset", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 1, 0, 1);
            checkOutput($sformatf("lock%0d", i), 1, 0, 0, (i < 3) ? i : 3);
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("unlock", 0, 1, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
